// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and constants for the multiply/divide unit
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int          WIDTH      = 32;
  localparam logic [5:0]  MULT_ITERS = 6'd16;
  localparam logic [5:0]  DIV_ITERS  = 6'd32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/multdiv_seq_if.sv
// rtl/multdiv_seq_if.sv - operand/control/result bundle between pipeline and multiply/divide unit
interface multdiv_seq_if;

  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/multdiv_seq_booth_recoder.sv
// rtl/multdiv_seq_booth_recoder.sv - radix-4 modified Booth digit recoder
module booth_recoder (
  input  logic [2:0] window,
  output logic       zero,
  output logic       one,
  output logic       two,
  output logic       negate
);

  // Map {b(i+1), b(i), b(i-1)} to a digit in {-2,-1,0,+1,+2}.
  always_comb begin
    zero   = (window == 3'b000) || (window == 3'b111);
    one    = (window == 3'b001) || (window == 3'b010) ||
             (window == 3'b101) || (window == 3'b110);
    two    = (window == 3'b011) || (window == 3'b100);
    negate = window[2] & ~(window[1] & window[0]);
  end

endmodule

// File: rtl/register32.sv
// rtl/register32.sv - 32-bit write-enabled register with asynchronous clear
module register32 (
  input  logic        clock,
  input  logic        clr,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Capture d when enabled; clear immediately on clr.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - multi-cycle signed 32-bit Booth multiplier / non-restoring divider
module multdiv_seq
  import multdiv_pkg::*;
(
  input  logic         clock,
  input  logic         clr,
  multdiv_seq_if.slave bus
);

  state_t      state;
  logic [5:0]  iterCount;
  logic [31:0] regA, regB;
  logic [31:0] resultReg;
  logic        excReg, rdyReg;

  logic startMult, startDiv, startAny, illegal;
  assign startMult = bus.ctrl_MULT & ~bus.ctrl_DIV;
  assign startDiv  = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign startAny  = startMult | startDiv;
  assign illegal   = bus.ctrl_MULT & bus.ctrl_DIV;

  register32 latchA (.clock(clock), .clr(clr), .we(startAny), .d(bus.data_operandA), .q(regA));
  register32 latchB (.clock(clock), .clr(clr), .we(startAny), .d(bus.data_operandB), .q(regB));

  // Multiplier datapath: {hiAcc, loAcc, qm1} shifts right two bits per iteration.
  logic [33:0] hiAcc;
  logic [31:0] loAcc;
  logic        qm1;
  logic        bZero, bOne, bTwo, bNeg;
  logic [33:0] aExt, ppMag, pp, boothSum;

  booth_recoder recoder (
    .window ({loAcc[1:0], qm1}),
    .zero   (bZero),
    .one    (bOne),
    .two    (bTwo),
    .negate (bNeg)
  );

  // Select the Booth partial product and add it to the upper accumulator.
  always_comb begin
    aExt = {{2{regA[31]}}, regA};
    case ({bZero, bOne, bTwo})
      3'b010:  ppMag = aExt;
      3'b001:  ppMag = {aExt[32:0], 1'b0};
      default: ppMag = '0;
    endcase
    pp       = bNeg ? (~ppMag + 34'd1) : ppMag;
    boothSum = hiAcc + pp;
  end

  // Divider datapath: magnitudes only; sign fixed up when the result is stored.
  logic [32:0] remAcc, remShift, remNext;
  logic [31:0] quoAcc, quoNext, divisorMag, dividendMagIn, quoSigned;

  // One non-restoring step plus the magnitude/sign helpers.
  always_comb begin
    divisorMag    = regB[31] ? (~regB + 32'd1) : regB;
    dividendMagIn = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
    remShift      = {remAcc[31:0], quoAcc[31]};
    remNext       = remAcc[32] ? (remShift + {1'b0, divisorMag})
                               : (remShift - {1'b0, divisorMag});
    quoNext       = {quoAcc[30:0], ~remNext[32]};
    quoSigned     = (regA[31] ^ regB[31]) ? (~quoAcc + 32'd1) : quoAcc;
  end

  // Control FSM with registered result, exception and ready pulse.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      iterCount <= '0;
      hiAcc     <= '0;
      loAcc     <= '0;
      qm1       <= 1'b0;
      remAcc    <= '0;
      quoAcc    <= '0;
      resultReg <= '0;
      excReg    <= 1'b0;
      rdyReg    <= 1'b0;
    end else if (illegal) begin
      state  <= IDLE;
      rdyReg <= 1'b0;
    end else if (startMult) begin
      state     <= MULT_RUN;
      iterCount <= '0;
      hiAcc     <= '0;
      loAcc     <= bus.data_operandB;
      qm1       <= 1'b0;
      rdyReg    <= 1'b0;
    end else if (startDiv) begin
      state     <= DIV_RUN;
      iterCount <= '0;
      remAcc    <= '0;
      quoAcc    <= dividendMagIn;
      rdyReg    <= 1'b0;
    end else begin
      case (state)
        MULT_RUN: begin
          if (iterCount == MULT_ITERS) begin
            state     <= DONE;
            resultReg <= loAcc;
            excReg    <= (hiAcc != {34{loAcc[31]}});
            rdyReg    <= 1'b1;
          end else begin
            hiAcc     <= {{2{boothSum[33]}}, boothSum[33:2]};
            loAcc     <= {boothSum[1:0], loAcc[31:2]};
            qm1       <= loAcc[1];
            iterCount <= iterCount + 6'd1;
          end
        end
        DIV_RUN: begin
          if (iterCount == DIV_ITERS) begin
            state  <= DONE;
            rdyReg <= 1'b1;
            if (regB == '0) begin
              resultReg <= '0;
              excReg    <= 1'b1;
            end else if (regA == INT_MIN && regB == 32'hFFFF_FFFF) begin
              resultReg <= INT_MIN;
              excReg    <= 1'b1;
            end else begin
              resultReg <= quoSigned;
              excReg    <= 1'b0;
            end
          end else begin
            remAcc    <= remNext;
            quoAcc    <= quoNext;
            iterCount <= iterCount + 6'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          rdyReg <= 1'b0;
        end
        default: begin
          rdyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = resultReg;
  assign bus.data_exception = excReg;
  assign bus.data_resultRDY = rdyReg;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - scoreboard bench for the multiply/divide unit
module tb_multdiv_seq;

  logic clock = 1'b0;
  logic clr   = 1'b1;
  int   cyc   = 0;
  int   checkCount = 0;
  int   errorCount = 0;

  multdiv_seq_if bus ();

  multdiv_seq dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Count rising edges so result latency can be checked in edges after E0.
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p;
    int          q;
    p = longint'($signed(a)) * longint'($signed(b));
    e.due = 0;
    if (!isDiv) begin
      e.result = p[31:0];
      e.exc    = (p[63:32] != {32{p[31]}});
    end else if (b == 32'd0) begin
      e.result = 32'd0;
      e.exc    = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.result = 32'h8000_0000;
      e.exc    = 1'b1;
    end else begin
      q        = $signed(a) / $signed(b);
      e.result = q;
      e.exc    = 1'b0;
    end
    return e;
  endfunction

  // Called on a falling edge: the next rising edge is E0. Any outstanding
  // expectation is dropped because a start aborts the running operation.
  task automatic startOp(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    sb.delete();
    e     = model(isDiv, a, b);
    e.due = cyc + 1 + (isDiv ? 33 : 17);
    sb.push_back(e);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = !isDiv;
    bus.ctrl_DIV      = isDiv;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checkVal("timeout", 64'd1, 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  // Scoreboard: every ready pulse must match the oldest expectation, including its edge.
  always @(negedge clock) begin
    exp_t e;
    if (!clr && bus.data_resultRDY) begin
      if (sb.size() == 0) begin
        checkVal("spuriousRdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkVal("result", {32'd0, bus.data_result}, {32'd0, e.result});
        checkVal("exception", {63'd0, bus.data_exception}, {63'd0, e.exc});
        checkVal("rdyCycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  logic [31:0] ra, rb;
  bit          rd;

  initial begin
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    repeat (2) @(negedge clock);
    checkVal("resetResult", {32'd0, bus.data_result}, 64'd0);
    checkVal("resetExc", {63'd0, bus.data_exception}, 64'd0);
    checkVal("resetRdy", {63'd0, bus.data_resultRDY}, 64'd0);
    clr = 1'b0;
    @(negedge clock);

    startOp(1'b0, 32'd7, -32'sd3);                  waitIdle(60);
    startOp(1'b0, 32'h0001_0000, 32'h0001_0000);    waitIdle(60);
    startOp(1'b1, -32'sd100, 32'd7);                waitIdle(60);
    startOp(1'b1, 32'd5, 32'd0);                    waitIdle(60);
    startOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);    waitIdle(60);
    startOp(1'b0, 32'h8000_0000, 32'h8000_0000);    waitIdle(60);
    startOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);    waitIdle(60);
    startOp(1'b1, 32'h8000_0000, 32'd1);            waitIdle(60);
    startOp(1'b1, 32'd3, -32'sd7);                  waitIdle(60);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      rd = i[0];
      startOp(rd, ra, rb);
      waitIdle(60);
    end

    // Abort a multiply with a divide at E5: only the divide may report.
    startOp(1'b0, 32'd3, 32'd4);
    repeat (4) @(negedge clock);
    startOp(1'b1, 32'd100, 32'd10);
    waitIdle(60);

    // Restart while in the ready cycle: the new operation still completes.
    startOp(1'b0, 32'd9, 32'd9);
    repeat (16) @(negedge clock);
    startOp(1'b1, -32'sd81, 32'd9);
    waitIdle(60);

    // Simultaneous starts abort without a result; outputs keep the last value.
    startOp(1'b0, 32'd6, 32'd6);
    repeat (3) @(negedge clock);
    sb.delete();
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    repeat (40) @(negedge clock);
    checkVal("illegalHoldResult", {32'd0, bus.data_result}, 64'hFFFF_FFF7);
    checkVal("illegalHoldExc", {63'd0, bus.data_exception}, 64'd0);

    // Asynchronous clear mid-multiply: outputs drop at once, no result follows.
    startOp(1'b1, 32'd100, 32'd10);
    waitIdle(60);
    startOp(1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    sb.delete();
    #2 clr = 1'b1;
    #1;
    checkVal("clrResult", {32'd0, bus.data_result}, 64'd0);
    checkVal("clrExc", {63'd0, bus.data_exception}, 64'd0);
    checkVal("clrRdy", {63'd0, bus.data_resultRDY}, 64'd0);
    @(negedge clock);
    clr = 1'b0;
    repeat (30) @(negedge clock);
    startOp(1'b0, 32'd2, 32'd2);
    waitIdle(60);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
